stream_mux_rr: RTL

- Parametrised N-channel, WIDTH-bit stream multiplexer. Generalises the combinational 4:1 mux into a flow-controlled, registered selector.
- Each input channel uses a valid/ready handshake. One output register stage sits between the channels and a single valid/ready consumer.
- Two selection modes: fixed select (external sel) and round-robin arbitration. Used as the merge point ahead of FSM datapaths.

---
 rtl/stream_mux_pkg.sv | 14 +
 rtl/stream_mux_rr_rr_arbiter.sv | 28 ++
 rtl/stream_mux_rr.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/stream_mux_pkg.sv
// Shared types for the stream multiplexer family: output-stage state and mode encodings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package stream_mux_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/stream_mux_rr_rr_arbiter.sv
// Round-robin arbiter: picks the first requester after ptr, wrapping modulo N.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the grant is consumed.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int SELW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] grant,
    output logic            grant_valid
);

    // Scan from farthest to nearest so the nearest requester after ptr wins.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        for (int k = N; k >= 1; k--) begin
            int idx;
            idx = (int'(ptr) + k) % N;
            if (req[idx]) begin
                grant       = SELW'(idx);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux, fixed-select or round-robin, one output register stage.
// Latency: one cycle from accepted input beat to out_valid; sustains one beat per cycle.
// Backpressure: out_ready low while FULL holds the beat and drops every in_ready. Optional packet lock: STREAM_MUX_LAST_LOCK_EN.
module stream_mux_rr #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int SELW  = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
`ifdef STREAM_MUX_LAST_LOCK_EN
    input  logic [N-1:0]         in_last,
    output logic                 out_last,
`endif
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    output logic [SELW-1:0]      out_chan,
    input  logic                 out_ready
);

    import stream_mux_pkg::*;

    state_t          state;
    state_t          state_nx;
    logic [SELW-1:0] rr_ptr;
    logic [SELW-1:0] arb_grant;
    logic            arb_valid;
    logic [SELW-1:0] grant;
    logic            grant_valid;
    logic            load_en;
    logic            accept;

`ifdef STREAM_MUX_LAST_LOCK_EN
    logic            locked;
    logic [SELW-1:0] lock_chan;
`endif

    rr_arbiter #(
        .N    (N),
        .SELW (SELW)
    ) u_arb (
        .req         (in_valid),
        .ptr         (rr_ptr),
        .grant       (arb_grant),
        .grant_valid (arb_valid)
    );

    assign out_valid = (state == FULL);
    // The output register can take a beat when empty or when its beat leaves this cycle.
    assign load_en   = (state == EMPTY) || (out_ready && out_valid);
    // Nothing is accepted while reset is held, even though the stage reads as empty.
    assign accept    = load_en && grant_valid && !rst;

    // Grant source: an open packet owns the mux, otherwise the selected mode decides.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
`ifdef STREAM_MUX_LAST_LOCK_EN
        if (locked) begin
            grant       = lock_chan;
            grant_valid = in_valid[lock_chan];
        end else
`endif
        if (mode == MODE_RR) begin
            grant       = arb_grant;
            grant_valid = arb_valid;
        end else if (int'(sel) < N) begin
            grant       = sel;
            grant_valid = in_valid[sel];
        end
    end

    // Ready goes only to the granted channel, so it is one-hot or zero.
    always_comb begin
        in_ready = '0;
        if (accept) begin
            in_ready[grant] = 1'b1;
        end
    end

    // Next-state logic: fill on accept, drain on out_ready, refill in the same cycle without a bubble.
    always_comb begin
        state_nx = state;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_nx = FULL;
                end
            end
            FULL: begin
                if (out_ready) begin
                    state_nx = accept ? FULL : EMPTY;
                end
            end
            default: state_nx = EMPTY;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nx;
        end
    end

    // Output register and round-robin pointer; data and channel hold when draining without refill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data <= '0;
            out_chan <= '0;
            rr_ptr   <= SELW'(N - 1);
        end else if (accept) begin
            out_data <= in_data[int'(grant)*WIDTH +: WIDTH];
            out_chan <= grant;
            if (mode == MODE_RR) begin
                rr_ptr <= grant;
            end
        end
    end

`ifdef STREAM_MUX_LAST_LOCK_EN
    // Packet lock: a non-final beat pins the grant to its channel until that channel's last beat is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_last  <= 1'b0;
            locked    <= 1'b0;
            lock_chan <= '0;
        end else if (accept) begin
            out_last  <= in_last[grant];
            locked    <= !in_last[grant];
            lock_chan <= grant;
        end
    end
`endif

endmodule
